param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, data_in and q width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: upper count bound, so the count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port data_in, input, WIDTH bits: load value.
REQ-006 Port ld, input, 1 bit: synchronous load request.
REQ-007 Port inc, input, 1 bit: count-up request.
REQ-008 Port dec, input, 1 bit: count-down request.
REQ-009 Port clr_ovf, input, 1 bit: synchronous clear of the sticky ovf flag.
REQ-010 Port q, output, WIDTH bits: registered count value.
REQ-011 Port tc, output, 1 bit: registered terminal-count pulse.
REQ-012 Port ovf, output, 1 bit: registered sticky overflow/underflow flag.

Function
REQ-013 Per-edge priority: ld, then inc XOR dec, then hold.
- ld=1 loads regardless of inc/dec.
- inc=dec=1 with ld=0 holds q.
REQ-014 Load clamping: ld loads min(data_in, MAX_VAL).
- A clamped load sets neither tc nor ovf.
REQ-015 inc with q<MAX_VAL gives q+1; dec with q>0 gives q-1; arithmetic is unsigned at WIDTH bits.
REQ-016 Boundary event:
- inc at q==MAX_VAL is an overflow event.
- dec at q==0 is an underflow event.
- Next q is as defined under Configuration.
REQ-017 tc timing:
- tc=1 for exactly the one cycle following an overflow or underflow event.
- tc=0 otherwise, including after loads and holds.
- Back-to-back events give tc high on consecutive cycles.
REQ-018 ovf behaviour:
- Set on the edge of any overflow or underflow event.
- Cleared on an edge where clr_ovf=1 and no event occurs.
- If an event and clr_ovf=1 occur together, set wins.
REQ-019 Latency: q, tc and ovf all reflect an edge's inputs one clock later; there are no combinational input-to-output paths.
REQ-020 Control inputs sampled X/Z are out of contract; the bench shall flag them and the RTL need not define q.

Reset
REQ-021 rst=1 forces q=0, tc=0 and ovf=0 immediately, without waiting for clk.
REQ-022 While rst=1, all inputs are ignored.
REQ-023 Deassertion is synchronous to the bench; the first count takes effect on the first rising clk edge with rst=0.
REQ-024 Reset asserted mid-operation discards any pending event: tc and ovf read 0 on the next cycle.

Configuration
REQ-025 Macro PARAM_COUNTER_SAT_EN selects saturating versus wrapping counting.
REQ-026 Without PARAM_COUNTER_SAT_EN (wrap mode):
- An overflow event gives q=0.
- An underflow event gives q=MAX_VAL.
REQ-027 With PARAM_COUNTER_SAT_EN (saturate mode):
- An overflow event holds q at MAX_VAL.
- An underflow event holds q at 0.
- tc and ovf behave exactly as in REQ-017 and REQ-018.
REQ-028 The port list and parameter list shall be identical in both builds.

Verification
REQ-029 Defaults, wrap build: rst pulse, then ld=1 data_in=8'hFE, then inc for 3 cycles.
- Required: q = FE, FF, 00, 01.
- tc=1 only in the cycle q=00.
- ovf=1 from that cycle onward.
REQ-030 Defaults, SAT build, same stimulus as REQ-029.
- Required: q = FE, FF, FF, FF.
- tc=1 in each of the two cycles after the two saturated events.
- ovf=1.
REQ-031 MAX_VAL=9, wrap build, q=0: dec once, then ld data_in=8'd20, then inc once.
- Required: q=9 with tc=1 and ovf=1.
- Then q=9 (clamped) with tc=0.
- Then q=0 with tc=1.
REQ-032 Defaults: ld with data_in=8'h55 in the same cycle as inc=dec=1; then inc=dec=1 alone.
- Required: q=55 after the first edge and still 55 after the second.
- tc=0 throughout.
REQ-033 Defaults, q=FF, ovf=1: assert inc and clr_ovf together, then clr_ovf alone.
- Required: ovf stays 1 after the first edge (set wins) and goes to 0 after the second.
REQ-034 Defaults, q=FF, inc=1: assert rst mid-cycle between edges.
- Required: q=0, tc=0 and ovf=0 before the next rising clk.
- No tc pulse follows the deassertion of rst.

Source files
------------

// File: rtl/param_counter.sv
// Up/down counter with load clamping, a one-cycle terminal-count pulse and a sticky overflow flag.
// Build option: define PARAM_COUNTER_SAT_EN for saturating bounds; by default the count wraps.
module param_counter #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Next value after stepping past either bound.
`ifdef PARAM_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] OVER_VAL  = MAX_VAL;
  localparam logic [WIDTH-1:0] UNDER_VAL = '0;
`else
  localparam logic [WIDTH-1:0] OVER_VAL  = '0;
  localparam logic [WIDTH-1:0] UNDER_VAL = MAX_VAL;
`endif

  logic             up;
  logic             down;
  logic             at_max;
  logic             at_zero;
  logic             bound_evt;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    up        = inc & ~dec;
    down      = dec & ~inc;
    at_max    = (q == MAX_VAL);
    at_zero   = (q == '0);
    ld_val    = (data_in > MAX_VAL) ? MAX_VAL : data_in;
    // A load always pre-empts counting, so it can never raise a boundary event.
    bound_evt = ~ld & ((up & at_max) | (down & at_zero));
    q_next    = q;
    if (ld) begin
      q_next = ld_val;
    end else if (up) begin
      q_next = at_max ? OVER_VAL : q + 1'b1;
    end else if (down) begin
      q_next = at_zero ? UNDER_VAL : q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      tc  <= bound_evt;
      ovf <= bound_evt | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: a default-parameter instance and a MAX_VAL=9 instance share stimulus
// and are checked against an arithmetic reference model plus directed expected values.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld, inc, dec, clr_ovf;
  logic [7:0] data_in;
  logic [7:0] q0, q9;
  logic       tc0, tc9, ovf0, ovf9;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = default instance, 1 = MAX_VAL=9 instance.
  int unsigned m_q[2];
  bit          m_tc[2];
  bit          m_ovf[2];
  int unsigned maxv[2] = '{255, 9};

`ifdef PARAM_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  param_counter dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
    .clr_ovf(clr_ovf), .q(q0), .tc(tc0), .ovf(ovf0)
  );

  param_counter #(.WIDTH(8), .MAX_VAL(8'd9)) dut9 (
    .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
    .clr_ovf(clr_ovf), .q(q9), .tc(tc9), .ovf(ovf9)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
    end
  endfunction

  // Count range is 0..max, so wrapping is modular arithmetic over max+1 values.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      int unsigned rng = maxv[k] + 1;
      bit ev = 1'b0;
      if (ld) begin
        m_q[k] = (data_in > maxv[k]) ? maxv[k] : data_in;
      end else if (inc && !dec) begin
        ev = (m_q[k] == maxv[k]);
        m_q[k] = (SAT && ev) ? maxv[k] : (m_q[k] + 1) % rng;
      end else if (dec && !inc) begin
        ev = (m_q[k] == 0);
        m_q[k] = (SAT && ev) ? 0 : (m_q[k] + rng - 1) % rng;
      end
      m_tc[k]  = ev;
      m_ovf[k] = ev ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[k]);
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".q0"},   32'(q0),   m_q[0]);
    chk({tag, ".tc0"},  32'(tc0),  32'(m_tc[0]));
    chk({tag, ".ovf0"}, 32'(ovf0), 32'(m_ovf[0]));
    chk({tag, ".q9"},   32'(q9),   m_q[1]);
    chk({tag, ".tc9"},  32'(tc9),  32'(m_tc[1]));
    chk({tag, ".ovf9"}, 32'(ovf9), 32'(m_ovf[1]));
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
  task automatic step(input string tag, input bit l, input bit i, input bit d, input bit c,
                      input logic [7:0] din);
    ld = l; inc = i; dec = d; clr_ovf = c; data_in = din;
    @(posedge clk);
    checks++;
    assert (!$isunknown({rst, ld, inc, dec, clr_ovf})) else begin
      errors++;
      $error("FAIL %s.ctrl_known: got %b expected no X/Z", tag, {rst, ld, inc, dec, clr_ovf});
    end
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  // Asynchronous reset pulse starting between edges; outputs must clear before any clock.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_model({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_model({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; inc = 1'b0; dec = 1'b0; clr_ovf = 1'b0; data_in = 8'h00;
    #1 model_reset();
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load near the top then count through the bound.
    step("r29_ld", 1, 0, 0, 0, 8'hFE);
    chk("r29_q_fe", 32'(q0), 32'hFE);
    chk("r29_q9_clamp", 32'(q9), 32'd9);
    step("r29_inc1", 0, 1, 0, 0, 8'h00);
    chk("r29_q_ff", 32'(q0), 32'hFF);
    chk("r29_tc_0", 32'(tc0), 32'd0);
    step("r29_inc2", 0, 1, 0, 0, 8'h00);
    chk("r29_q_bound", 32'(q0), SAT ? 32'hFF : 32'h00);
    chk("r29_tc_1", 32'(tc0), 32'd1);
    chk("r29_ovf_1", 32'(ovf0), 32'd1);
    step("r29_inc3", 0, 1, 0, 0, 8'h00);
    chk("r29_q_after", 32'(q0), SAT ? 32'hFF : 32'h01);
    chk("r29_tc_after", 32'(tc0), SAT ? 32'd1 : 32'd0);
    chk("r29_ovf_sticky", 32'(ovf0), 32'd1);

    // Small MAX_VAL: underflow, clamped load, overflow.
    reset_pulse("r31_rst");
    step("r31_dec", 0, 0, 1, 0, 8'h00);
    chk("r31_q_under", 32'(q9), SAT ? 32'd0 : 32'd9);
    chk("r31_tc_under", 32'(tc9), 32'd1);
    chk("r31_ovf_under", 32'(ovf9), 32'd1);
    step("r31_ld20", 1, 0, 0, 0, 8'd20);
    chk("r31_q_clamp", 32'(q9), 32'd9);
    chk("r31_tc_clamp", 32'(tc9), 32'd0);
    step("r31_inc", 0, 1, 0, 0, 8'h00);
    chk("r31_q_over", 32'(q9), SAT ? 32'd9 : 32'd0);
    chk("r31_tc_over", 32'(tc9), 32'd1);

    // Load beats simultaneous inc/dec; inc+dec alone holds.
    step("r32_ld", 1, 1, 1, 0, 8'h55);
    chk("r32_q_ld", 32'(q0), 32'h55);
    chk("r32_tc_ld", 32'(tc0), 32'd0);
    step("r32_hold", 0, 1, 1, 0, 8'h00);
    chk("r32_q_hold", 32'(q0), 32'h55);
    chk("r32_tc_hold", 32'(tc0), 32'd0);

    // Event and clr_ovf together: set wins; clr_ovf alone clears.
    step("r33_ld", 1, 0, 0, 0, 8'hFF);
    step("r33_evt", 0, 1, 0, 0, 8'h00);
    step("r33_reld", 1, 0, 0, 0, 8'hFF);
    chk("r33_ovf_pre", 32'(ovf0), 32'd1);
    step("r33_both", 0, 1, 0, 1, 8'h00);
    chk("r33_ovf_setwins", 32'(ovf0), 32'd1);
    step("r33_clr", 0, 0, 0, 1, 8'h00);
    chk("r33_ovf_cleared", 32'(ovf0), 32'd0);

    // Reset between edges with an overflow pending.
    step("r34_ld", 1, 0, 0, 0, 8'hFF);
    ld = 1'b0; inc = 1'b1;
    reset_pulse("r34_rst");
    chk("r34_q", 32'(q0), 32'd0);
    chk("r34_ovf", 32'(ovf0), 32'd0);
    step("r34_after", 0, 0, 0, 0, 8'h00);
    chk("r34_tc_none", 32'(tc0), 32'd0);

    // Randomised traffic, biased towards loads near both bounds.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] din;
      case ($urandom_range(0, 3))
        0: din = 8'($urandom_range(250, 255));
        1: din = 8'($urandom_range(0, 11));
        default: din = 8'($urandom_range(0, 255));
      endcase
      step("rand", $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, din);
      if (n % 97 == 96) reset_pulse("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
